qif_scheduler: RTL and testbench
================================

QIF_SCHEDULER -- requirements
Module: qif_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4: number of virtual neurons time-multiplexed on one QIF update datapath; fixed at 4 in this revision.
REQ-002 Parameter V_PEAK, default 50: signed spike threshold.
REQ-003 Parameter V_RESET, default -20: signed post-spike membrane value.
REQ-004 Parameter A_SHIFT, default 5: quadratic gain as a right shift (gain 1/32).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-high despite the name.
REQ-007 step_start  in  1  request one integration step for all neurons.
REQ-008 I_syn_bus  in  32  four signed 8-bit synaptic inputs; neuron k is bits [8k+7:8k].
REQ-009 v_wr_en  in  1  host write of one membrane value.
REQ-010 v_wr_idx  in  2  neuron index for host write.
REQ-011 v_wr_data  in  8  signed value for host write.
REQ-012 v_rd_idx  in  2  neuron index for readback.
REQ-013 V_mem  out  8  registered signed membrane value of neuron v_rd_idx.
REQ-014 step_busy  out  1  high while a step is in progress.
REQ-015 step_done  out  1  one-cycle pulse at step completion.
REQ-016 spike_vec  out  4  per-neuron spike flags from the last completed step.

Function
REQ-017 The FSM SHALL have states IDLE, UPDATE and DONE; UPDATE carries a 2-bit neuron index idx.
REQ-018 In IDLE, step_start=1 SHALL latch I_syn_bus into an internal register, clear idx to 0 and enter UPDATE at the same edge.
REQ-019 step_start SHALL be ignored in UPDATE and DONE; it does not queue.
REQ-020 Each UPDATE cycle SHALL update exactly neuron idx and then increment idx. Neurons 0..3 are updated at the 1st..4th edges after the start edge; after idx=3 the FSM enters DONE.
REQ-021 DONE SHALL last one cycle with step_done=1 and then return to IDLE. step_done is high in the 5th cycle after the start cycle.
REQ-022 step_busy SHALL be 1 in UPDATE and DONE, and 0 in IDLE.
REQ-023 Update arithmetic for neuron k SHALL be: sq = V*V, an exact 16-bit unsigned product; term = sq >> A_SHIFT; sum = V + term + I_k, evaluated in at least 18-bit signed.
REQ-024 If sum >= V_PEAK, V_k SHALL become V_RESET and spike bit k SHALL be set.
REQ-025 Otherwise V_k SHALL become sum saturated to [-128, 127] and spike bit k SHALL be cleared.
REQ-026 The compare against V_PEAK SHALL use the unsaturated sum.
REQ-027 spike_vec SHALL be built in a shadow register during UPDATE and copied to the output at the DONE entry edge. It holds until the next DONE or reset.
REQ-028 A host write (v_wr_en=1) SHALL take effect only in IDLE. It is ignored in UPDATE and DONE, with no error flag.
REQ-029 If step_start and v_wr_en are both 1 in IDLE, the write SHALL commit first. The step then uses the written value.
REQ-030 V_mem SHALL be registered: the value of V[v_rd_idx] after the current edge's updates appears one cycle after v_rd_idx is presented.

Reset
REQ-031 With rst_n=1 at a rising edge, the following SHALL hold after that edge: all four V = 0; V_mem = 0; spike_vec = 0; shadow spikes = 0; latched inputs = 0; state IDLE; idx = 0; step_busy = 0; step_done = 0.
REQ-032 Reset SHALL take priority over step_start and v_wr_en. A reset during UPDATE or DONE abandons the step with no step_done pulse.

Verification
REQ-033 Neuron 0 integration: V0=0, I0=10, four steps -> V0 = 10, 23, 49 with spike 0; fourth step V0=-20 with spike_vec[0]=1.
REQ-034 Negative saturation: write V1=-20, I1=-128, one step -> V1=-128, spike_vec[1]=0.
REQ-035 Large negative input: V2=0, I2=-128, two steps -> first step V2=-128; second step sum=256, so V2=-20 with spike_vec[2]=1.
REQ-036 Timing and handshake: step_start pulsed at cycle 0 -> step_busy high in cycles 1-5 and step_done high only in cycle 5.
  - step_start re-asserted in cycles 2-5 produces no extra step.
  - v_wr_en during cycle 3 leaves V unchanged.
REQ-037 Reset mid-step: rst_n=1 in cycle 2 of a step -> next cycle all V=0, spike_vec=0, IDLE, no step_done pulse.
REQ-038 Simultaneous events: v_wr_en with V3=49 and step_start with I3=0 in the same IDLE cycle -> step uses 49, sum=124, so V3=-20 and spike_vec[3]=1.

Source files
------------

// File: rtl/qif_scheduler.sv
// Quadratic integrate-and-fire scheduler: N_NEURONS virtual neurons share one
// update datapath, one neuron per cycle, after a step request.
module qif_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int V_PEAK    = 50,
  parameter int V_RESET   = -20,
  parameter int A_SHIFT   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_start,
  input  logic [31:0] I_syn_bus,
  input  logic        v_wr_en,
  input  logic [1:0]  v_wr_idx,
  input  logic [7:0]  v_wr_data,
  input  logic [1:0]  v_rd_idx,
  output logic [7:0]  V_mem,
  output logic        step_busy,
  output logic        step_done,
  output logic [3:0]  spike_vec
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam logic [1:0]        LAST_IDX = 2'(N_NEURONS - 1);
  localparam logic signed [17:0] PEAK    = 18'(V_PEAK);
  localparam logic signed [7:0]  VRST    = 8'(V_RESET);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic signed [7:0] v_q [N_NEURONS];
  logic signed [7:0] v_d [N_NEURONS];
  logic [31:0]       isyn_q, isyn_d;
  logic [3:0]        spk_sh_q, spk_sh_d;
  logic [3:0]        spike_q, spike_d;
  logic signed [7:0] vmem_q, vmem_d;

  logic signed [7:0]  v_cur;
  logic signed [7:0]  i_cur;
  logic signed [15:0] prod;
  logic [15:0]        term;
  logic signed [17:0] sum;
  logic               fire;

  function automatic logic signed [7:0] sat8(input logic signed [17:0] s);
    if (s > 18'sd127)  return 8'sd127;
    if (s < -18'sd128) return -8'sd128;
    return s[7:0];
  endfunction

  // Shared update datapath for the neuron selected by idx_q
  always_comb begin
    v_cur = v_q[idx_q];
    i_cur = $signed(isyn_q[{idx_q, 3'b000} +: 8]);
    prod  = v_cur * v_cur;
    term  = $unsigned(prod) >> A_SHIFT;
    sum   = {{10{v_cur[7]}}, v_cur} + {2'b00, term} + {{10{i_cur[7]}}, i_cur};
    fire  = (sum >= PEAK);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_busy = (state_q != S_IDLE);
    step_done = (state_q == S_DONE);
  end

  // Host write lands before the step latch, so a same-cycle step sees it
  always_comb begin
    v_d      = v_q;
    isyn_d   = isyn_q;
    spk_sh_d = spk_sh_q;
    spike_d  = spike_q;
    case (state_q)
      S_IDLE: begin
        if (v_wr_en)    v_d[v_wr_idx] = v_wr_data;
        if (step_start) isyn_d = I_syn_bus;
      end
      S_UPDATE: begin
        v_d[idx_q]      = fire ? VRST : sat8(sum);
        spk_sh_d[idx_q] = fire;
        if (idx_q == LAST_IDX) spike_d = spk_sh_d;
      end
      default: ;
    endcase
    vmem_d = v_d[v_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) v_q[k] <= '0;
      isyn_q   <= '0;
      spk_sh_q <= '0;
      spike_q  <= '0;
      vmem_q   <= '0;
    end else begin
      v_q      <= v_d;
      isyn_q   <= isyn_d;
      spk_sh_q <= spk_sh_d;
      spike_q  <= spike_d;
      vmem_q   <= vmem_d;
    end
  end

  assign V_mem     = vmem_q;
  assign spike_vec = spike_q;

endmodule

// File: tb/tb_qif_scheduler.sv
// Directed bench for qif_scheduler with a behavioural QIF model feeding a scoreboard.
module tb_qif_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, step_start, v_wr_en;
  logic [31:0] I_syn_bus;
  logic [1:0]  v_wr_idx, v_rd_idx;
  logic [7:0]  v_wr_data;
  logic [7:0]  V_mem;
  logic        step_busy, step_done;
  logic [3:0]  spike_vec;

  always #5 clk = ~clk;

  qif_scheduler dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .I_syn_bus(I_syn_bus),
    .v_wr_en(v_wr_en), .v_wr_idx(v_wr_idx), .v_wr_data(v_wr_data),
    .v_rd_idx(v_rd_idx), .V_mem(V_mem), .step_busy(step_busy),
    .step_done(step_done), .spike_vec(spike_vec)
  );

  typedef struct packed {
    logic [31:0] v;
    logic [3:0]  spk;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mv[4];
  logic [3:0] mspk;
  int   exp033[4] = '{10, 23, 49, -20};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference QIF update on plain integers
  function automatic void model_step(input logic [31:0] ib);
    for (int k = 0; k < 4; k++) begin
      int i;
      int s;
      i = $signed(ib[8*k +: 8]);
      s = mv[k] + (mv[k] * mv[k]) / 32 + i;
      if (s >= 50) begin
        mv[k]   = -20;
        mspk[k] = 1'b1;
      end else begin
        mv[k]   = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        mspk[k] = 1'b0;
      end
    end
  endfunction

  function automatic exp_t pack_model();
    exp_t e;
    for (int k = 0; k < 4; k++) e.v[8*k +: 8] = 8'(mv[k]);
    e.spk = mspk;
    return e;
  endfunction

  task automatic check_vals(input exp_t e);
    for (int k = 0; k < 4; k++) begin
      v_rd_idx = 2'(k);
      tick();
      chk($sformatf("v%0d", k), $signed(V_mem), $signed(e.v[8*k +: 8]));
    end
  endtask

  task automatic read_v(input int k, input int exp, input string tag);
    v_rd_idx = 2'(k);
    tick();
    chk(tag, $signed(V_mem), exp);
  endtask

  task automatic host_write(input logic [1:0] idx, input logic [7:0] data);
    v_wr_en = 1'b1; v_wr_idx = idx; v_wr_data = data;
    mv[idx] = $signed(data);
    tick();
    v_wr_en = 1'b0;
  endtask

  task automatic run_step(input logic we, input logic [1:0] widx,
                          input logic [7:0] wdata, input logic [31:0] ib);
    exp_t e;
    logic got;
    v_wr_en = we; v_wr_idx = widx; v_wr_data = wdata;
    if (we) mv[widx] = $signed(wdata);
    I_syn_bus  = ib;
    step_start = 1'b1;
    model_step(ib);
    sbq.push_back(pack_model());
    tick();
    step_start = 1'b0;
    v_wr_en    = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (step_done) got = 1'b1;
      else tick();
    end
    chk("done_seen", got, 1);
    e = sbq.pop_front();
    chk("spike_vec", spike_vec, e.spk);
    tick();
    check_vals(e);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b1; step_start = 1'b0; I_syn_bus = '0;
    v_wr_en = 1'b0; v_wr_idx = '0; v_wr_data = '0; v_rd_idx = '0;
    for (int k = 0; k < 4; k++) mv[k] = 0;
    mspk = '0;
    tick();
    tick();
    rst_n = 1'b0;
    chk("rst_busy", step_busy, 0);
    chk("rst_done", step_done, 0);
    chk("rst_spike", spike_vec, 0);
    chk("rst_vmem", V_mem, 0);

    // Neuron 0 integrates toward threshold, spiking on the fourth step
    for (int s = 0; s < 4; s++) begin
      run_step(1'b0, 2'd0, 8'd0, 32'h0000_000A);
      read_v(0, exp033[s], "req033_v0");
    end
    chk("req033_spk0", spike_vec[0], 1);

    host_write(2'd1, 8'hEC);
    run_step(1'b0, 2'd0, 8'd0, 32'h0000_8000);
    read_v(1, -128, "req034_v1");
    chk("req034_spk1", spike_vec[1], 0);

    host_write(2'd2, 8'h00);
    run_step(1'b0, 2'd0, 8'd0, 32'h0080_0000);
    read_v(2, -128, "req035_v2a");
    run_step(1'b0, 2'd0, 8'd0, 32'h0080_0000);
    read_v(2, -20, "req035_v2b");
    chk("req035_spk2", spike_vec[2], 1);

    run_step(1'b1, 2'd3, 8'd49, 32'h0000_0000);
    read_v(3, -20, "req038_v3");
    chk("req038_spk3", spike_vec[3], 1);

    // Handshake timing with ignored re-starts and a blocked host write
    I_syn_bus  = 32'h0101_0101;
    step_start = 1'b1;
    model_step(I_syn_bus);
    sbq.push_back(pack_model());
    tick();
    e = '0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t_busy_c%0d", c), step_busy, 1);
      chk($sformatf("t_done_c%0d", c), step_done, (c == 5));
      if (c == 5) begin
        e = sbq.pop_front();
        chk("t_spike", spike_vec, e.spk);
      end
      step_start = (c <= 4);
      v_wr_en    = (c == 2);
      v_wr_idx   = 2'd0;
      v_wr_data  = 8'h4D;
      tick();
    end
    step_start = 1'b0;
    v_wr_en    = 1'b0;
    chk("t_idle_busy", step_busy, 0);
    chk("t_idle_done", step_done, 0);
    tick();
    chk("t_idle2_busy", step_busy, 0);
    check_vals(e);

    // Reset in the middle of a step
    I_syn_bus  = 32'h0505_0505;
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("r_busy", step_busy, 0);
    chk("r_done", step_done, 0);
    chk("r_spike", spike_vec, 0);
    chk("r_vmem", V_mem, 0);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (step_done) n++;
      tick();
    end
    chk("r_nodone", n, 0);
    for (int k = 0; k < 4; k++) mv[k] = 0;
    mspk = '0;
    check_vals(pack_model());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
